// File: rtl/image_scan_controller.sv
// Raster sequencer: walks a WIDTH x HEIGHT frame row-major over a combinational
// image source and re-presents the returned pixels as a valid/ready stream.
module image_scan_controller #(
    parameter int WIDTH  = 390,
    parameter int HEIGHT = 80,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          continuous,
    output logic          src_enable,
    output logic [CW-1:0] row,
    output logic [CW-1:0] column,
    input  logic          src_r,
    input  logic          src_g,
    input  logic          src_b,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_r,
    output logic          pix_g,
    output logic          pix_b,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_eof,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [2:0]    rgb_q, rgb_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;
    logic          done_q, done_d;

    logic free;
    logic at_last_col;
    logic at_last_row;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        rgb_d   = rgb_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        done_d  = 1'b0;

        free        = !valid_q || pix_ready;
        at_last_col = (col_q == LAST_COL);
        at_last_row = (row_q == LAST_ROW);

        case (state_q)
            IDLE: begin
                row_d = '0;
                col_d = '0;
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // A free slot both retires the held pixel and captures the next one.
                if (free) begin
                    rgb_d   = {src_r, src_g, src_b};
                    valid_d = 1'b1;
                    sof_d   = (row_q == '0) && (col_q == '0);
                    eol_d   = at_last_col;
                    eof_d   = at_last_col && at_last_row;
                    if (at_last_col) begin
                        col_d = '0;
                        if (at_last_row) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (valid_q && pix_ready) begin
                    valid_d = 1'b0;
                    rgb_d   = 3'b000;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = continuous ? SCAN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            rgb_q   <= 3'b000;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            rgb_q   <= rgb_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    // The source is enabled exactly while the sequencer is busy.
    assign src_enable = busy_q;
    assign busy       = busy_q;
    assign row        = row_q;
    assign column     = col_q;
    assign pix_valid  = valid_q;
    assign pix_r      = rgb_q[2];
    assign pix_g      = rgb_q[1];
    assign pix_b      = rgb_q[0];
    assign pix_sof    = sof_q;
    assign pix_eol    = eol_q;
    assign pix_eof    = eof_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_image_scan_controller.sv
// Directed bench for image_scan_controller on a reduced 20x80 frame, with a
// source model that lights only pixels (0,0), (0,10) and (70,0).
module tb_image_scan_controller;

    localparam int W  = 20;
    localparam int H  = 80;
    localparam int CW = 16;
    localparam int N  = W * H;
    localparam int FRAME_LIMIT = N + 200;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          continuous;
    logic          src_enable;
    logic [CW-1:0] row;
    logic [CW-1:0] column;
    logic          src_r, src_g, src_b;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_r, pix_g, pix_b;
    logic          pix_sof, pix_eol, pix_eof;
    logic          busy;
    logic          frame_done;
    logic          lit_px;

    int checks;
    int failures;

    image_scan_controller #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .src_enable (src_enable),
        .row        (row),
        .column     (column),
        .src_r      (src_r),
        .src_g      (src_g),
        .src_b      (src_b),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        lit_px = ((row == 16'd0) && (column == 16'd0)) ||
                 ((row == 16'd0) && (column == 16'd10)) ||
                 ((row == 16'd70) && (column == 16'd0));
    end
    assign src_r = lit_px;
    assign src_g = lit_px;
    assign src_b = lit_px;

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes one frame from the current negedge, checking every accepted beat
    // against the raster model and every stalled cycle for a frozen output.
    task automatic consume_frame(input bit bp, input bit eof_stall, input bit start_poke,
                                 output int beats, output int bad, output bit done_ok);
        int cyc, low3, lowe, r, c;
        bit tog, stalled, finished;
        logic exp_lit;
        logic [2:0] h_rgb, h_mk;
        logic [CW-1:0] h_row, h_col;
        beats = 0; bad = 0; done_ok = 0; cyc = 0; low3 = 0; lowe = 0;
        tog = 0; stalled = 0; finished = 0;
        h_rgb = '0; h_mk = '0; h_row = '0; h_col = '0;
        while (cyc < FRAME_LIMIT && !finished) begin
            pix_ready = 1'b1;
            start     = 1'b0;
            if (bp && beats == 3 && low3 < 7) begin
                pix_ready = 1'b0;
                low3++;
            end else if (bp && beats >= W - 5 && beats <= W + 5) begin
                pix_ready = tog;
                tog = !tog;
            end
            if (eof_stall && beats == N - 1 && lowe < 4) begin
                pix_ready = 1'b0;
                lowe++;
                if (src_enable !== 1'b1 || busy !== 1'b1) bad++;
            end
            if (start_poke && (beats == 50 || beats == N - 1)) start = 1'b1;
            if (stalled) begin
                if ({pix_r, pix_g, pix_b} !== h_rgb || {pix_sof, pix_eol, pix_eof} !== h_mk ||
                    row !== h_row || column !== h_col || pix_valid !== 1'b1) begin
                    $display("[TB] note: beat %0d changed while stalled", beats);
                    bad++;
                end
            end
            if (frame_done !== 1'b0) bad++;
            stalled = pix_valid && !pix_ready;
            h_rgb = {pix_r, pix_g, pix_b};
            h_mk  = {pix_sof, pix_eol, pix_eof};
            h_row = row;
            h_col = column;
            if (pix_valid && pix_ready) begin
                r = beats / W;
                c = beats % W;
                exp_lit = (r == 0 && c == 0) || (r == 0 && c == 10) || (r == 70 && c == 0);
                if ({pix_r, pix_g, pix_b} !== {3{exp_lit}} || pix_sof !== (beats == 0) ||
                    pix_eol !== (c == W - 1) || pix_eof !== (beats == N - 1)) begin
                    if (bad < 5)
                        $display("[TB] note: beat %0d rgb=%b sof=%b eol=%b eof=%b, want rgb=%b sof=%b eol=%b eof=%b",
                                 beats, {pix_r, pix_g, pix_b}, pix_sof, pix_eol, pix_eof,
                                 {3{exp_lit}}, beats == 0, c == W - 1, beats == N - 1);
                    bad++;
                end
                beats++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (beats == N) begin
                finished = 1;
                if (frame_done === 1'b1 && pix_valid === 1'b0) done_ok = 1;
                else bad++;
            end
        end
        if (!finished) bad++;
        pix_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({src_enable, row, column, pix_valid, pix_r, pix_g, pix_b, pix_sof, pix_eol,
             pix_eof, busy, frame_done} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: row=%0d col=%0d valid=%b busy=%b, want all 0",
                     row, column, pix_valid, busy);
        end
        rst_n = 1'b1;
        pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, pix_valid);
        end
    endtask

    task automatic test_single_frame();
        int beats, bad;
        bit done_ok;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, src_enable, pix_valid} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL start_latency1: busy/en/valid=%b, want 110", {busy, src_enable, pix_valid});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_sof, pix_r, pix_g, pix_b} !== 5'b11111 || row !== 16'd0 || column !== 16'd1) begin
            failures++;
            $display("[TB] FAIL first_pixel: valid/sof/rgb=%b row=%0d col=%0d, want 11111 0 1",
                     {pix_valid, pix_sof, pix_r, pix_g, pix_b}, row, column);
        end
        consume_frame(0, 0, 0, beats, bad, done_ok);
        checks++;
        if (beats !== N) begin
            failures++;
            $display("[TB] FAIL single_beats: got %0d want %0d", beats, N);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL single_content: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (done_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_frame_done: got %b want 1", done_ok);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({frame_done, busy, src_enable, pix_valid, pix_sof, pix_eol, pix_eof} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL single_idle: done/busy/en/valid/markers=%b, want 0000000",
                     {frame_done, busy, src_enable, pix_valid, pix_sof, pix_eol, pix_eof});
        end
    endtask

    task automatic test_backpressure();
        int beats, bad;
        bit done_ok;
        kick();
        consume_frame(1, 0, 0, beats, bad, done_ok);
        checks++;
        if (beats !== N || bad !== 0 || done_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure: beats=%0d bad=%0d done=%b, want %0d 0 1", beats, bad, done_ok, N);
        end
    endtask

    task automatic test_start_ignored();
        int beats, bad, seen;
        bit done_ok;
        kick();
        consume_frame(0, 1, 1, beats, bad, done_ok);
        checks++;
        if (beats !== N || bad !== 0 || done_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_ignored_frame: beats=%0d bad=%0d done=%b, want %0d 0 1", beats, bad, done_ok, N);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || pix_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL start_ignored_extra: %0d busy cycles after frame, want 0", seen);
        end
    endtask

    task automatic test_eof_stall();
        int beats, bad;
        bit done_ok;
        kick();
        consume_frame(0, 1, 0, beats, bad, done_ok);
        checks++;
        if (beats !== N || bad !== 0 || done_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL eof_stall: beats=%0d bad=%0d done=%b, want %0d 0 1", beats, bad, done_ok, N);
        end
    endtask

    task automatic test_continuous();
        int beats, bad;
        bit done_ok;
        continuous = 1'b1;
        kick();
        consume_frame(0, 0, 0, beats, bad, done_ok);
        checks++;
        if (beats !== N || bad !== 0 || done_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cont_frame1: beats=%0d bad=%0d done=%b, want %0d 0 1", beats, bad, done_ok, N);
        end
        checks++;
        if (busy !== 1'b1 || pix_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cont_gap: busy=%b valid=%b, want 1 0", busy, pix_valid);
        end
        continuous = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_sof, frame_done} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL cont_sof: valid/sof/done=%b, want 110", {pix_valid, pix_sof, frame_done});
        end
        consume_frame(0, 0, 0, beats, bad, done_ok);
        checks++;
        if (beats !== N || bad !== 0 || done_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cont_frame2: beats=%0d bad=%0d done=%b, want %0d 0 1", beats, bad, done_ok, N);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cont_stop: busy=%b done=%b, want 0 0", busy, frame_done);
        end
    endtask

    task automatic test_reset_mid_scan();
        int cnt, seen;
        kick();
        cnt = 0;
        while (!(row == 16'd5 && column == 16'd10) && cnt < N + 10) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (row !== 16'd5 || column !== 16'd10) begin
            failures++;
            $display("[TB] FAIL reach_5_10: row=%0d col=%0d, want 5 10", row, column);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({src_enable, row, column, pix_valid, pix_r, pix_g, pix_b, pix_sof, pix_eol,
             pix_eof, busy, frame_done} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: row=%0d col=%0d valid=%b busy=%b, want all 0",
                     row, column, pix_valid, busy);
        end
        #7 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || pix_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL no_resume: %0d active cycles after reset, want 0", seen);
        end
        kick();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pix_valid, pix_sof} !== 2'b11 || column !== 16'd1 || row !== 16'd0) begin
            failures++;
            $display("[TB] FAIL restart_sof: valid/sof=%b row=%0d col=%0d, want 11 0 1",
                     {pix_valid, pix_sof}, row, column);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_start_ignored();
        test_eof_stall();
        test_continuous();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_scan_controller.md
Name: image_scan_controller

Overview:
- Raster sequencer for the combinational image source block (1-bit frame buffer, row/column in, r/g/b out).
- Walks every (row, column) of a WIDTH x HEIGHT frame in row-major order and drives the source's enable/row/column.
- Captures the returned r/g/b into a one-entry output register and presents it as a valid/ready pixel stream with start/end-of-frame/end-of-line markers.
- Sits between the image source and the display/serializer stage.

Parameters:
- WIDTH, 390, pixels per row.
- HEIGHT, 80, rows per frame.
- CW, 16, coordinate width for row/column; WIDTH-1 and HEIGHT-1 must fit in CW bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- continuous  in  1  when 1 at end of frame, the next frame starts without a new start.
- src_enable  out  1  enable to the image source.
- row  out  CW  row address to the image source.
- column  out  CW  column address to the image source.
- src_r, src_g, src_b  in  1 each  pixel returned by the image source, combinational from row/column.
- pix_valid  out  1  output pixel register holds data.
- pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
- pix_r, pix_g, pix_b  out  1 each  captured pixel.
- pix_sof  out  1  captured pixel is (0,0).
- pix_eol  out  1  captured pixel is column WIDTH-1.
- pix_eof  out  1  captured pixel is (HEIGHT-1, WIDTH-1).
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the eof pixel is accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE; row=0, column=0, src_enable=0, pix_valid=0, all pix_* data/markers=0, busy=0, frame_done=0. No partial frame resumes.
- All outputs are registered.
- States are IDLE, SCAN, DRAIN.
- IDLE:
  - src_enable=0; coordinates held at 0.
  - start=1 -> SCAN on the next edge; src_enable=1 from that cycle.
- SCAN:
  - Define "free" as !pix_valid || pix_ready.
  - On a free cycle, the output register loads src_r/g/b at the current row/column.
  - On the same cycle, pix_valid=1 and the markers load from the current coordinates.
  - Coordinates then advance: column+1. If column==WIDTH-1, column=0 and row+1.
  - On the last pixel (HEIGHT-1, WIDTH-1), coordinates go to (0,0) and state -> DRAIN.
  - When not free (stall), coordinates and the output register hold unchanged.
  - If pix_valid && pix_ready && !free cannot occur, so no pixel is ever lost or duplicated.
- DRAIN:
  - src_enable stays 1; no new capture.
  - When the eof pixel is accepted, pix_valid=0 and frame_done=1 for exactly the next cycle.
  - The state leaves DRAIN on that edge: to SCAN if continuous=1 (sampled on the acceptance cycle), else to IDLE with src_enable=0.
- Latency:
  - start at edge N -> SCAN from N+1 -> first pixel pix_valid=1 after edge N+2 with pix_sof=1.
  - With pix_ready held at 1, throughput is one pixel per cycle.
  - A full frame is WIDTH*HEIGHT = 31200 beats; frame_done follows the eof acceptance by one cycle.
  - In continuous mode, the next frame's sof pixel is valid two cycles after the eof acceptance.
- Other rules:
  - start while busy has no effect; start and continuous are both ignored in DRAIN except as described above.
  - Markers (sof/eol/eof) are valid only while pix_valid=1; otherwise they are 0.
  - Row/column compare against WIDTH-1 and HEIGHT-1 at CW bits; the counters never exceed those values.

Test Plan:
- Reset mid-SCAN at row 5, column 100, with rst_n low for 1 cycle asynchronously -> all outputs 0 immediately; after release, no pixel until a new start.
- Source with only pixels (0,0), (0,10) and (70,0) lit; start pulse; pix_ready=1 -> beat 0 has rgb=111 and sof=1; beat 10 has rgb=111; beat 27300 has rgb=111; all other beats have rgb=000; eol on beats 389, 779, ...; eof only on beat 31199; frame_done one cycle after; returns to IDLE.
- Backpressure: pix_ready low for 7 cycles at beat 3, and toggled every cycle over beats 385-395 -> captured pixel held stable, coordinates frozen; exactly 31200 accepted beats in order with no duplicates.
- start asserted again during SCAN and in DRAIN with continuous=0 -> ignored; exactly one frame produced.
- continuous=1 -> second frame sof valid two cycles after first eof acceptance; frame_done pulses once per frame.
- Stall on the eof beat for 4 cycles -> state remains DRAIN; frame_done only after acceptance.
